// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: state codes, opcode/funct
// values, ALU control words and datapath mux selects.
package mc_pkg;

    localparam int FIELD_W = 6;
    localparam int ALU_W   = 3;
    localparam int STATE_W = 4;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_FETCH   = 4'd0;
    localparam state_t ST_DECODE  = 4'd1;
    localparam state_t ST_MEMADR  = 4'd2;
    localparam state_t ST_MEMRD   = 4'd3;
    localparam state_t ST_MEMWB   = 4'd4;
    localparam state_t ST_MEMWR   = 4'd5;
    localparam state_t ST_EXECUTE = 4'd6;
    localparam state_t ST_ALUWB   = 4'd7;
    localparam state_t ST_BRANCH  = 4'd8;
    localparam state_t ST_ADDIEX  = 4'd9;
    localparam state_t ST_ADDIWB  = 4'd10;
    localparam state_t ST_JUMP    = 4'd11;

    localparam logic [FIELD_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [FIELD_W-1:0] OP_LW    = 6'b100011;
    localparam logic [FIELD_W-1:0] OP_SW    = 6'b101011;
    localparam logic [FIELD_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [FIELD_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [FIELD_W-1:0] OP_J     = 6'b000010;

    localparam logic [FIELD_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FIELD_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FIELD_W-1:0] FN_AND = 6'b100100;
    localparam logic [FIELD_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FIELD_W-1:0] FN_SLT = 6'b101010;
    localparam logic [FIELD_W-1:0] FN_XOR = 6'b100110;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;
    localparam logic [ALU_W-1:0] ALU_XOR = 3'b110;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Which operation the FSM wants from the ALU in the current state.
    typedef enum logic [1:0] {
        OPC_ADD   = 2'b00,
        OPC_SUB   = 2'b01,
        OPC_FUNCT = 2'b10
    } alu_op_e;

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps the FSM's requested ALU operation class (and funct for R-type) onto the
// ALU control word; flags funct codes the datapath does not implement.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  alu_op_e            alu_op,
    input  logic [FIELD_W-1:0] funct,
    output logic [ALU_W-1:0]   alu_control,
    output logic               funct_illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            OPC_ADD: alu_control = ALU_ADD;
            OPC_SUB: alu_control = ALU_SUB;
            OPC_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    FN_XOR:  alu_control = ALU_XOR;
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Main control FSM of the multi-cycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback and drives every datapath select and enable.
module mc_control_unit
    import mc_pkg::*;
#(
    parameter int OP_W   = 6,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   opcode,
    input  logic [OP_W-1:0]   funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              iord,
    output logic              mem_req,
    output logic              mem_write,
    output logic              ir_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              reg_write,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [CTRL_W-1:0] alu_control,
    output logic [1:0]        pc_src,
    output logic              pc_en,
    output logic              illegal_op
);

    state_t  state, state_next;
    alu_op_e alu_op;
    logic    funct_illegal;
    logic    mem_req_raw, mem_write_raw, ir_write_raw, reg_write_raw;
    logic    pc_en_raw, illegal_raw;

    mc_alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (funct),
        .alu_control   (alu_control),
        .funct_illegal (funct_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
        if (!rst_n) state <= ST_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = ST_FETCH;
        iord          = 1'b0;
        mem_req_raw   = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write_raw = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = OPC_ADD;
        pc_src        = PC_ALU;
        pc_en_raw     = 1'b0;
        illegal_raw   = 1'b0;

        case (state)
            ST_FETCH: begin
                mem_req_raw  = 1'b1;
                alu_src_b    = SRCB_FOUR;
                ir_write_raw = mem_ready;
                pc_en_raw    = mem_ready;
                state_next   = mem_ready ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                // Branch target is computed speculatively here and parked in ALUOut.
                alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OP_LW, OP_SW: state_next = ST_MEMADR;
                    OP_RTYPE:     state_next = ST_EXECUTE;
                    OP_BEQ:       state_next = ST_BRANCH;
                    OP_ADDI:      state_next = ST_ADDIEX;
                    OP_J:         state_next = ST_JUMP;
                    default:      illegal_raw = 1'b1;
                endcase
            end
            ST_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                state_next = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                mem_req_raw = 1'b1;
                iord        = 1'b1;
                state_next  = mem_ready ? ST_MEMWB : ST_MEMRD;
            end
            ST_MEMWB: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
            end
            ST_MEMWR: begin
                mem_req_raw   = 1'b1;
                iord          = 1'b1;
                mem_write_raw = mem_ready;
                state_next    = mem_ready ? ST_FETCH : ST_MEMWR;
            end
            ST_EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_op      = OPC_FUNCT;
                illegal_raw = funct_illegal;
                state_next  = funct_illegal ? ST_FETCH : ST_ALUWB;
            end
            ST_ALUWB: begin
                reg_write_raw = 1'b1;
                reg_dst       = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = OPC_SUB;
                pc_src    = PC_ALUOUT;
                pc_en_raw = zero;
            end
            ST_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                state_next = ST_ADDIWB;
            end
            ST_ADDIWB: reg_write_raw = 1'b1;
            ST_JUMP: begin
                pc_src    = PC_JUMP;
                pc_en_raw = 1'b1;
            end
            default: state_next = ST_FETCH;
        endcase
    end

    // Strobes are cut combinationally so nothing is written once reset is asserted.
    assign mem_req    = mem_req_raw   & rst_n;
    assign mem_write  = mem_write_raw & rst_n;
    assign ir_write   = ir_write_raw  & rst_n;
    assign reg_write  = reg_write_raw & rst_n;
    assign pc_en      = pc_en_raw     & rst_n;
    assign illegal_op = illegal_raw   & rst_n;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: each instruction is expanded into its
// expected per-cycle control timeline and compared against the DUT every cycle.
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       iord, mem_req, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, pc_en, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;

    mc_control_unit #(.OP_W(6), .CTRL_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .mem_req(mem_req), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .pc_src(pc_src), .pc_en(pc_en), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Bit order: iord, mem_req, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
    // alu_src_a, alu_src_b[1:0], alu_control[2:0], pc_src[1:0], pc_en, illegal_op
    logic [16:0] obs;
    assign obs = {iord, mem_req, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, alu_control, pc_src, pc_en, illegal_op};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // dyn: 0 static, 1 ir_write/pc_en follow mem_ready, 2 mem_write follows mem_ready, 3 pc_en follows zero
    typedef struct {
        string       name;
        logic [16:0] base;
        int          dyn;
        bit          waits;
    } step_t;

    step_t plan[$];
    int    fetch_lows = -1;
    int    mem_lows   = -1;
    int    zero_force = -1;

    function automatic step_t mk(string name, bit io, bit req, bit rdst, bit m2r, bit rw,
                                 bit sa, logic [1:0] sb, logic [2:0] alu, logic [1:0] ps,
                                 bit pce, bit ill, int dyn, bit waits);
        step_t s;
        s.name  = name;
        s.base  = {io, req, 1'b0, 1'b0, rdst, m2r, rw, sa, sb, alu, ps, pce, ill};
        s.dyn   = dyn;
        s.waits = waits;
        return s;
    endfunction

    // Returns {known, alu code} for an R-type funct.
    function automatic logic [3:0] alu_of(logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b1_000;
            6'b100010: return 4'b1_001;
            6'b100100: return 4'b1_010;
            6'b100101: return 4'b1_011;
            6'b101010: return 4'b1_101;
            6'b100110: return 4'b1_110;
            default:   return 4'b0_000;
        endcase
    endfunction

    task automatic build_plan(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] a;
        bit known;
        a = alu_of(fn);
        known = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
                (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
        plan.delete();
        plan.push_back(mk("fetch", 0, 1, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 0, 0, 1, 1));
        plan.push_back(mk("decode", 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 2'b00, 0, !known, 0, 0));
        case (op)
            6'b100011: begin
                plan.push_back(mk("memadr", 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 0, 0, 0, 0));
                plan.push_back(mk("memrd", 1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0, 1));
                plan.push_back(mk("memwb", 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0));
            end
            6'b101011: begin
                plan.push_back(mk("memadr", 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 0, 0, 0, 0));
                plan.push_back(mk("memwr", 1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 2, 1));
            end
            6'b000000: begin
                plan.push_back(mk("execute", 0, 0, 0, 0, 0, 1, 2'b00, a[2:0], 2'b00, 0, !a[3], 0, 0));
                if (a[3])
                    plan.push_back(mk("aluwb", 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0));
            end
            6'b000100:
                plan.push_back(mk("branch", 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b01, 0, 0, 3, 0));
            6'b001000: begin
                plan.push_back(mk("addiex", 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 0, 0, 0, 0));
                plan.push_back(mk("addiwb", 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0));
            end
            6'b000010:
                plan.push_back(mk("jump", 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 1, 0, 0, 0));
            default: ;
        endcase
    endtask

    // Called at posedge+1 with mem_ready already driven; checks at negedge.
    task automatic one_cycle(input step_t s, input string tag);
        logic [16:0] e;
        zero = (zero_force >= 0) ? zero_force[0] : 1'($urandom);
        @(negedge clk);
        e = s.base;
        case (s.dyn)
            1: begin e[13] = mem_ready; e[1] = mem_ready; end
            2: e[14] = mem_ready;
            3: e[1] = zero;
            default: ;
        endcase
        check($sformatf("%s/%s", tag, s.name), obs, e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_steps(input int first, input int last, input string tag);
        int lows;
        for (int i = first; i <= last; i++) begin
            if (plan[i].waits) begin
                if (i == 0) lows = (fetch_lows >= 0) ? fetch_lows : int'($urandom_range(0, 3));
                else        lows = (mem_lows   >= 0) ? mem_lows   : int'($urandom_range(0, 3));
                for (int k = 0; k <= lows; k++) begin
                    mem_ready = (k == lows);
                    one_cycle(plan[i], tag);
                end
            end else begin
                mem_ready = 1'($urandom);
                one_cycle(plan[i], tag);
            end
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input string tag);
        build_plan(op, fn);
        opcode = op;
        funct  = fn;
        run_steps(0, plan.size() - 1, tag);
    endtask

    // FETCH selects with every strobe held low.
    localparam logic [16:0] RESET_EXP = {8'b0, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0};

    logic [5:0] ops [7];
    logic [5:0] fns [6];

    initial begin
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100110};

        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = 6'b000000; funct = 6'b000000;
        #12;
        check("reset_hold", obs, RESET_EXP);
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fetch_lows = 0; mem_lows = 0;
        run_instr(6'b000000, 6'b100000, "add");
        mem_lows = 2;
        run_instr(6'b100011, 6'b000000, "lw_wait2");
        mem_lows = 0;
        zero_force = 1; run_instr(6'b000100, 6'b000000, "beq_taken");
        zero_force = 0; run_instr(6'b000100, 6'b000000, "beq_not");
        zero_force = -1;
        run_instr(6'b111111, 6'b000000, "illegal_op");
        run_instr(6'b000000, 6'b000000, "illegal_fn");
        run_instr(6'b001000, 6'b000000, "addi");
        run_instr(6'b000010, 6'b000000, "j");
        run_instr(6'b101011, 6'b000000, "sw");

        // Reset in the middle of a store that is completing this very cycle.
        build_plan(6'b101011, 6'b000000);
        opcode = 6'b101011;
        run_steps(0, 2, "sw_rst");
        mem_ready = 1'b1;
        zero = 1'b0;
        @(negedge clk);
        check("sw_rst/memwr_before", obs, 17'b1_1_1_0_0_0_0_0_00_000_00_0_0);
        #1;
        rst_n = 1'b0;
        #1;
        check("sw_rst/mem_write_cut", obs, RESET_EXP);
        @(negedge clk);
        check("sw_rst/held", obs, RESET_EXP);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_instr(6'b000000, 6'b100010, "after_rst");

        fetch_lows = -1; mem_lows = -1;
        for (int n = 0; n < 300; n++) begin
            logic [5:0] op, fn;
            op = ops[$urandom_range(0, 6)];
            if (op == 6'b111111 && $urandom_range(0, 1) == 1) op = 6'($urandom);
            fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            run_instr(op, fn, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
